// File: rtl/a2f_pkt_scheduler.sv
// a2f_pkt_scheduler: shares the A2F FIFO between the IQ sample stream and the
// control-response channel. Each grant emits one framed packet: a header word
// {type, seq, len} followed by a fixed-length payload. Packets never interleave.
module a2f_pkt_scheduler #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 256,
    parameter int unsigned RSP_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  smp_avail,
    input  logic [DATA_WIDTH-1:0] smp_data,
    input  logic                  smp_valid,
    output logic                  smp_ready,
    input  logic                  rsp_pending,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  rsp_valid,
    input  logic                  rsp_last,
    output logic                  rsp_ready,
    input  logic                  fifo_full,
    output logic                  fifo_wr,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    output logic                  busy,
    output logic                  rsp_err,
    output logic [11:0]           pkt_seq
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_SMP  = 3'd2;
    localparam logic [2:0] ST_RSP  = 3'd3;
    localparam logic [2:0] ST_PAD  = 3'd4;

    localparam logic GNT_SMP = 1'b0;
    localparam logic GNT_RSP = 1'b1;

    localparam logic [15:0] BURST_W = 16'(BURST_LEN);
    localparam logic [15:0] RSP_W   = 16'(RSP_LEN);

    logic [2:0]  state;
    logic [15:0] cnt;
    logic        last_grant;
    logic [11:0] seq;
    logic        err;

    logic        grant_any;
    logic        grant_rsp;
    logic [31:0] hdr_word;

    // Arbitration: a lone requester wins; with both present, alternate
    // against whoever was granted last.
    assign grant_any = enable & (smp_avail | rsp_pending);
    assign grant_rsp = rsp_pending & (~smp_avail | (last_grant == GNT_SMP));

    assign hdr_word = {(last_grant == GNT_RSP) ? 4'h2 : 4'h1, seq,
                       (last_grant == GNT_RSP) ? RSP_W : BURST_W};

    assign busy    = (state != ST_IDLE);
    assign rsp_err = err;
    assign pkt_seq = seq;

    // Write-side outputs decoded from the current state; source handshakes
    // only fire together with an accepted FIFO write.
    always_comb begin
        fifo_wr    = 1'b0;
        fifo_wdata = '0;
        smp_ready  = 1'b0;
        rsp_ready  = 1'b0;
        case (state)
            ST_HDR: begin
                fifo_wr    = ~fifo_full;
                fifo_wdata = DATA_WIDTH'(hdr_word);
            end
            ST_SMP: begin
                fifo_wr    = smp_valid & ~fifo_full;
                fifo_wdata = smp_data;
                smp_ready  = smp_valid & ~fifo_full;
            end
            ST_RSP: begin
                fifo_wr    = rsp_valid & ~fifo_full;
                fifo_wdata = rsp_data;
                rsp_ready  = rsp_valid & ~fifo_full;
            end
            ST_PAD: begin
                fifo_wr    = ~fifo_full;
            end
            default: ;
        endcase
    end

    // Packet FSM, payload word counter, sequence number and sticky framing error.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_grant <= GNT_SMP;
            seq        <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        last_grant <= grant_rsp ? GNT_RSP : GNT_SMP;
                        state      <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (fifo_wr) begin
                        seq   <= seq + 12'd1;
                        cnt   <= '0;
                        state <= (last_grant == GNT_RSP) ? ST_RSP : ST_SMP;
                    end
                end
                ST_SMP: begin
                    if (fifo_wr) begin
                        if (cnt == BURST_W - 16'd1) begin
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                ST_RSP: begin
                    if (fifo_wr) begin
                        if (cnt == RSP_W - 16'd1) begin
                            // Missing last marker: close anyway; the source's
                            // leftover words become a later packet.
                            if (!rsp_last) err <= 1'b1;
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end else if (rsp_last) begin
                            // Short response: zero-fill to the advertised length.
                            err   <= 1'b1;
                            cnt   <= cnt + 16'd1;
                            state <= ST_PAD;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                ST_PAD: begin
                    if (fifo_wr) begin
                        if (cnt == RSP_W - 16'd1) begin
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2f_pkt_scheduler.sv
// Scoreboard bench for a2f_pkt_scheduler: stimulus pushes expected FIFO words,
// a negedge monitor pops and compares every write the DUT presents.
module tb_a2f_pkt_scheduler;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          smp_avail = 1'b0;
    logic [DW-1:0] smp_data;
    logic          smp_valid = 1'b1;
    logic          smp_ready;
    logic          rsp_pending = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_valid = 1'b1;
    logic          rsp_last;
    logic          rsp_ready;
    logic          fifo_full = 1'b0;
    logic          fifo_wr;
    logic [DW-1:0] fifo_wdata;
    logic          busy;
    logic          rsp_err;
    logic [11:0]   pkt_seq;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    logic [DW-1:0] exp_q[$];
    int            exp_seq = 0;
    int            exp_smp = 0;
    int            exp_rsp = 0;

    // Source models: incrementing data words, advanced on each handshake.
    logic [31:0] smp_idx = 0;
    logic [31:0] rsp_idx = 0;
    int          rsp_pos = 0;
    int          rsp_last_at = 3;

    a2f_pkt_scheduler #(.DATA_WIDTH(32), .BURST_LEN(4), .RSP_LEN(4)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .smp_avail(smp_avail), .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
        .rsp_pending(rsp_pending), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
        .rsp_last(rsp_last), .rsp_ready(rsp_ready),
        .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
        .busy(busy), .rsp_err(rsp_err), .pkt_seq(pkt_seq)
    );

    always #5 clk = ~clk;

    assign smp_data = 32'hA0 + smp_idx;
    assign rsp_data = 32'hC0 + rsp_idx;
    assign rsp_last = (rsp_pos == rsp_last_at);

    always @(posedge clk) begin
        if (smp_valid && smp_ready) smp_idx <= smp_idx + 1;
        if (rsp_valid && rsp_ready) begin
            rsp_idx <= rsp_idx + 1;
            rsp_pos <= rsp_last ? 0 : rsp_pos + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [3:0] t, input int s);
        logic [11:0] s12;
        s12 = 12'(s);
        return {t, s12, 16'd4};
    endfunction

    task automatic push_smp_pkt();
        exp_q.push_back(hdr(4'h1, exp_seq));
        exp_seq = (exp_seq + 1) % 4096;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'hA0 + 32'(exp_smp));
            exp_smp++;
        end
    endtask

    task automatic push_rsp_pkt(input int nwords);
        exp_q.push_back(hdr(4'h2, exp_seq));
        exp_seq = (exp_seq + 1) % 4096;
        for (int i = 0; i < 4; i++) begin
            if (i < nwords) begin
                exp_q.push_back(32'hC0 + 32'(exp_rsp));
                exp_rsp++;
            end else begin
                exp_q.push_back(32'h0);
            end
        end
    endtask

    // Monitor: every presented write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (fifo_wr) begin
            wr_cnt++;
            if (fifo_full) begin
                errors++;
                $display("FAIL wr_while_full actual=1 expected=0");
            end
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_write actual=%h expected=none", fifo_wdata);
            end else begin
                chk("fifo_wdata", fifo_wdata, exp_q.pop_front());
            end
        end
        if ((smp_ready || rsp_ready) && !fifo_wr) begin
            errors++;
            $display("FAIL ready_without_wr actual=1 expected=0");
        end
    end

    task automatic wait_busy(input logic lvl, input string name);
        int n = 0;
        @(negedge clk);
        while (busy !== lvl && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy !== lvl) begin
            errors++;
            $display("FAIL timeout_%s actual=%b expected=%b", name, busy, lvl);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_fifo_wr"}, 32'(fifo_wr), 0);
        chk({tag, "_pkt_seq"}, 32'(pkt_seq), 0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
        chk({tag, "_ready"}, 32'(smp_ready | rsp_ready), 0);
    endtask

    initial begin
        int base;
        int n;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check_reset_outs("rst");
        reset_n = 1'b1;

        // T1: single sample packet; enable drops once granted
        push_smp_pkt();
        base = wr_cnt;
        enable = 1'b1; smp_avail = 1'b1;
        wait_busy(1'b1, "t1_start");
        enable = 1'b0;
        wait_busy(1'b0, "t1_end");
        chk("t1_writes", 32'(wr_cnt - base), 5);
        chk("t1_pkt_seq", 32'(pkt_seq), 1);
        repeat (5) @(negedge clk);
        chk("t1_no_new_pkt", 32'(wr_cnt - base), 5);
        chk("t1_idle", 32'(busy), 0);

        // T2: both requesters -> RSP, SMP, RSP, SMP
        push_rsp_pkt(4); push_smp_pkt(); push_rsp_pkt(4); push_smp_pkt();
        rsp_pending = 1'b1; enable = 1'b1;
        for (int p = 0; p < 4; p++) begin
            wait_busy(1'b1, "t2_start");
            if (p == 3) enable = 1'b0;
            wait_busy(1'b0, "t2_end");
        end
        rsp_pending = 1'b0; smp_avail = 1'b0;
        chk("t2_pkt_seq", 32'(pkt_seq), 5);

        // T3: FIFO full for 3 cycles after the 2nd sample word
        push_smp_pkt();
        smp_avail = 1'b1; enable = 1'b1;
        wait_busy(1'b1, "t3_start");
        enable = 1'b0; smp_avail = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            if (fifo_wr && smp_ready) n++;
            if (n < 2) @(negedge clk);
        end
        @(posedge clk); #1;
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall_wr", 32'(fifo_wr), 0);
            chk("t3_stall_ready", 32'(smp_ready), 0);
        end
        @(posedge clk); #1;
        fifo_full = 1'b0;
        wait_busy(1'b0, "t3_end");

        // T4: early rsp_last on 2nd word -> 2 zero pad words, sticky error
        push_rsp_pkt(2);
        rsp_last_at = 1;
        rsp_pending = 1'b1; enable = 1'b1;
        wait_busy(1'b1, "t4_start");
        enable = 1'b0; rsp_pending = 1'b0;
        wait_busy(1'b0, "t4_end");
        chk("t4_rsp_err", 32'(rsp_err), 1);
        rsp_last_at = 3;
        push_rsp_pkt(4);
        rsp_pending = 1'b1; enable = 1'b1;
        wait_busy(1'b1, "t4b_start");
        enable = 1'b0; rsp_pending = 1'b0;
        wait_busy(1'b0, "t4b_end");
        chk("t4_rsp_err_sticky", 32'(rsp_err), 1);

        // T6b: reset in the middle of a response packet
        exp_q.push_back(hdr(4'h2, exp_seq));
        exp_q.push_back(32'hC0 + 32'(exp_rsp));
        exp_q.push_back(32'hC0 + 32'(exp_rsp + 1));
        exp_rsp += 2;
        base = wr_cnt;
        rsp_pending = 1'b1; enable = 1'b1;
        n = 0;
        @(negedge clk); #1;
        while (wr_cnt < base + 3 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (wr_cnt < base + 3) begin
            errors++;
            $display("FAIL timeout_t6_mid_rsp actual=%0d expected=%0d", wr_cnt - base, 3);
        end
        reset_n = 1'b0; enable = 1'b0; rsp_pending = 1'b0;
        @(negedge clk);
        check_reset_outs("mid_rst");
        reset_n = 1'b1;
        exp_seq = 0;

        // T5: sequence wrap over 4097 back-to-back sample packets
        for (int p = 0; p < 4097; p++) push_smp_pkt();
        smp_avail = 1'b1; enable = 1'b1;
        for (int p = 0; p < 4097; p++) begin
            wait_busy(1'b1, "t5_start");
            if (p == 4096) enable = 1'b0;
            wait_busy(1'b0, "t5_end");
        end
        smp_avail = 1'b0;
        chk("t5_pkt_seq", 32'(pkt_seq), 1);

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/a2f_pkt_scheduler.md
Name: a2f_pkt_scheduler

Overview:
Packet scheduler in front of the A2F (FPGA-to-host) FIFO that feeds the FT600 write path. It shares the FIFO between two requesters: the IQ sample stream and the control-response channel. Each grant becomes one framed packet (header word plus fixed-length payload), and packets never interleave. Sequence numbering lets the host detect lost packets.

Parameters:
DATA_WIDTH, 32, FIFO word width; header layout requires 32.
BURST_LEN, 256, sample payload words per packet (1..65535).
RSP_LEN, 4, response payload words per packet (1..65535).

Ports:
clk  input  1  system clock; all logic on posedge.
reset_n  input  1  synchronous, active-low reset.
enable  input  1  allow new packets; the current packet always completes.
smp_avail  input  1  sample source holds >= BURST_LEN words.
smp_data  input  DATA_WIDTH  sample word.
smp_valid  input  1  smp_data valid.
smp_ready  output  1  sample word consumed this cycle (smp_valid & smp_ready).
rsp_pending  input  1  a response packet is waiting.
rsp_data  input  DATA_WIDTH  response word.
rsp_valid  input  1  rsp_data valid.
rsp_last  input  1  final response word marker.
rsp_ready  output  1  response word consumed this cycle.
fifo_full  input  1  A2F FIFO cannot accept a write this cycle.
fifo_wr  output  1  A2F FIFO write strobe.
fifo_wdata  output  DATA_WIDTH  A2F FIFO write data.
busy  output  1  state != IDLE.
rsp_err  output  1  sticky: response framing mismatch.
pkt_seq  output  12  sequence number of the next header.

Behaviour:
- Reset (synchronous, reset_n=0 at posedge):
  - state=IDLE; pkt_seq=0; word counter=0; rsp_err=0; last_grant=SMP.
  - All outputs 0 in the following cycle.
  - Reset mid-packet abandons the packet (no padding).
- States: IDLE, HDR, SMP, RSP, PAD.
- Outputs are combinational from registered state and inputs.
  - fifo_wr is never asserted while fifo_full=1.
  - smp_ready/rsp_ready are asserted only together with fifo_wr.
- IDLE:
  - If enable=1, choose a requester: candidates are smp_avail and rsp_pending.
  - If only one candidate, grant it.
  - If both: grant RSP if last_grant=SMP, else SMP (alternating fairness).
  - Record the grant in last_grant and go to HDR next cycle.
  - If enable=0 or no candidate, stay in IDLE.
- HDR:
  - fifo_wdata = {type[3:0], pkt_seq[11:0], len[15:0]}.
  - type: 4'h1 for sample, 4'h2 for response. len: BURST_LEN or RSP_LEN.
  - fifo_wr=~fifo_full. On a write, pkt_seq increments (wrapping 4095->0) and state goes to SMP or RSP with word counter=0.
  - If fifo_full, hold state.
- SMP:
  - fifo_wr = smp_valid & ~fifo_full; fifo_wdata=smp_data; smp_ready=fifo_wr.
  - Counter increments per write. After write BURST_LEN-1, go to IDLE.
  - smp_avail is ignored after the grant.
- RSP:
  - fifo_wr = rsp_valid & ~fifo_full; fifo_wdata=rsp_data; rsp_ready=fifo_wr.
  - Last expected word is counter=RSP_LEN-1:
    - Written with rsp_last=1: go to IDLE.
    - Written with rsp_last=0: rsp_err<=1, go to IDLE. Remaining source words form a later packet.
  - rsp_last=1 written at counter<RSP_LEN-1: rsp_err<=1, go to PAD.
- PAD:
  - fifo_wdata=0; fifo_wr=~fifo_full; rsp_ready=0.
  - Writes zero words until the total payload is RSP_LEN, then go to IDLE.
- Throughput: one word per clk when the source is valid and the FIFO is not full.
  - Minimum packet time is 1+len cycles, plus 1 IDLE cycle between packets.
- fifo_full asserting mid-payload stalls the packet with no word loss or duplication; data must not be taken from the source during the stall.
- enable=0 mid-packet: the packet finishes, then the block stays in IDLE.
- rsp_err clears only on reset.

Test Plan:
1. BURST_LEN=4, smp_avail=1, words 0xA0..0xA3, rsp_pending=0 -> FIFO receives 0x10000004, 0xA0, 0xA1, 0xA2, 0xA3; pkt_seq 0->1; busy drops after the 5th write.
2. smp_avail=1 and rsp_pending=1 continuously, RSP_LEN=4 -> packets alternate RSP, SMP, RSP, SMP. Headers are 0x20000004, 0x10010004, 0x20020004...; no payload interleaving.
3. fifo_full=1 for 3 cycles after the 2nd sample word -> fifo_wr and smp_ready stay 0 for those 3 cycles; all 4 payload words appear once, in order.
4. RSP_LEN=4, rsp_last=1 on the 2nd word -> FIFO receives header, 2 data words, 2 zero words; rsp_err=1, and it stays 1 after later good packets.
5. Force 4096 packets -> the 4096th header carries seq 0xFFF, the next carries 0x000.
6. enable=0 during the SMP payload -> packet completes and no new header follows. reset_n=0 mid-RSP -> the next cycle shows IDLE, fifo_wr=0, pkt_seq=0, rsp_err=0.
